// File: rtl/plic_pkg.sv
// rtl/plic_pkg.sv - register map and shared constants for plic_lite
package plic_pkg;

    localparam logic [7:0] PLIC_PRIO_BASE   = 8'h00;
    localparam logic [7:0] PLIC_PEND        = 8'h80;
    localparam logic [7:0] PLIC_EN          = 8'h84;
    localparam logic [7:0] PLIC_THR         = 8'h88;
    localparam logic [7:0] PLIC_CLAIM       = 8'h8C;

    localparam int PLIC_ID_W        = 5;
    localparam int PLIC_NOTIF_CAUSE = 11;

endpackage

// File: rtl/plic_lite_if.sv
// rtl/plic_lite_if.sv - single-cycle register bus between core and plic_lite
interface plic_lite_if;

    logic        bus_valid;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ready
    );

endinterface

// File: rtl/plic_gateway.sv
// rtl/plic_gateway.sv - level-triggered gateway holding pending/in_service for one source
module plic_gateway (
    input  logic clk,
    input  logic resetn,
    input  logic irq,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic pending,
    output logic in_service
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending    <= 1'b0;
            in_service <= 1'b0;
        end else if (claim_hit) begin
            // claim wins over a gateway set on the same edge
            pending    <= 1'b0;
            in_service <= 1'b1;
        end else begin
            if (complete_hit && in_service) begin
                in_service <= 1'b0;
            end
            if (irq && !pending && !in_service) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/plic_lite.sv
// rtl/plic_lite.sv - minimal PLIC: gateways, priority/enable/threshold, claim/complete
module plic_lite
    import plic_pkg::*;
#(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [NSRC-1:0] irq_src,
    plic_lite_if.slave      bus,
    output logic            PLIC_notif
);

    logic [PRIO_W-1:0]    prio [1:NSRC];
    logic [NSRC:1]        en;
    logic [NSRC:1]        pend;
    logic [NSRC:1]        insvc;
    logic [PRIO_W-1:0]    thr;
    logic [PLIC_ID_W-1:0] win_id;
    logic [PRIO_W-1:0]    win_prio;
    logic                 rd_req;
    logic                 wr_req;
    logic                 claim_req;
    logic                 cmpl_req;
    logic [31:0]          rd_data;
    logic                 unused_bits;

    assign rd_req    = bus.bus_valid && !bus.bus_we;
    assign wr_req    = bus.bus_valid &&  bus.bus_we;
    assign claim_req = rd_req && (bus.bus_addr == PLIC_CLAIM);
    assign cmpl_req  = wr_req && (bus.bus_addr == PLIC_CLAIM);

    assign unused_bits = ^{bus.bus_wdata, PLIC_NOTIF_CAUSE[0]};

    // strict '>' while scanning upward keeps the lowest ID on ties
    always_comb begin
        win_id   = '0;
        win_prio = '0;
        for (int i = 1; i <= NSRC; i++) begin
            if (pend[i] && en[i] && (prio[i] > thr) && (prio[i] > win_prio)) begin
                win_id   = PLIC_ID_W'(i);
                win_prio = prio[i];
            end
        end
    end

    assign PLIC_notif = (win_id != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 1; i <= NSRC; i++) begin
                prio[i] <= '0;
            end
            en  <= '0;
            thr <= '0;
        end else if (wr_req) begin
            for (int i = 1; i <= NSRC; i++) begin
                if (bus.bus_addr == PLIC_PRIO_BASE + 8'(4 * i)) begin
                    prio[i] <= bus.bus_wdata[PRIO_W-1:0];
                end
            end
            if (bus.bus_addr == PLIC_EN) begin
                en <= bus.bus_wdata[NSRC:1];
            end
            if (bus.bus_addr == PLIC_THR) begin
                thr <= bus.bus_wdata[PRIO_W-1:0];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 1; i <= NSRC; i++) begin
            if (bus.bus_addr == PLIC_PRIO_BASE + 8'(4 * i)) begin
                rd_data[PRIO_W-1:0] = prio[i];
            end
        end
        case (bus.bus_addr)
            PLIC_PEND:  rd_data[NSRC:1]        = pend;
            PLIC_EN:    rd_data[NSRC:1]        = en;
            PLIC_THR:   rd_data[PRIO_W-1:0]    = thr;
            PLIC_CLAIM: rd_data[PLIC_ID_W-1:0] = win_id;
            default:    ;
        endcase
    end

    for (genvar g = 1; g <= NSRC; g++) begin : g_gw
        plic_gateway u_gw (
            .clk          (clk),
            .resetn       (resetn),
            .irq          (irq_src[g-1]),
            .claim_hit    (claim_req && (win_id == PLIC_ID_W'(g))),
            .complete_hit (cmpl_req && (bus.bus_wdata[PLIC_ID_W-1:0] == PLIC_ID_W'(g))),
            .pending      (pend[g]),
            .in_service   (insvc[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.bus_ready <= 1'b0;
            bus.bus_rdata <= '0;
        end else begin
            bus.bus_ready <= bus.bus_valid;
            bus.bus_rdata <= rd_req ? rd_data : 32'd0;
        end
    end

endmodule

// File: tb/tb_plic_lite.sv
// tb/tb_plic_lite.sv - scoreboard bench for plic_lite
module tb_plic_lite;

    typedef struct {
        logic        is_rd;
        logic [7:0]  addr;
        logic [31:0] exp;
    } resp_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] irq_src = '0;
    logic       PLIC_notif;

    resp_t sb[$];
    resp_t mon_r;
    int    n_checks = 0;
    int    n_fail = 0;

    plic_lite_if bif ();

    plic_lite #(.NSRC(8), .PRIO_W(3)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .irq_src    (irq_src),
        .bus        (bif),
        .PLIC_notif (PLIC_notif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bif.bus_ready) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 32'd1, 32'd0);
            end else begin
                mon_r = sb.pop_front();
                if (mon_r.is_rd) check($sformatf("rd_%02h", mon_r.addr), bif.bus_rdata, mon_r.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic access(input logic we, input logic [7:0] addr, input logic [31:0] data,
                          input logic [31:0] exp);
        resp_t r;
        r.is_rd = !we;
        r.addr  = addr;
        r.exp   = exp;
        bif.bus_valid = 1'b1;
        bif.bus_we    = we;
        bif.bus_addr  = addr;
        bif.bus_wdata = data;
        sb.push_back(r);
        tick(1);
        bif.bus_valid = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        access(1'b1, addr, data, 32'd0);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] exp);
        access(1'b0, addr, 32'd0, exp);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        irq_src = '0;
        bif.bus_valid = 1'b0;
        tick(2);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.bus_valid = 1'b0;
        bif.bus_we    = 1'b0;
        bif.bus_addr  = '0;
        bif.bus_wdata = '0;

        // reset state, and a request under reset gets no response
        tick(2);
        check("rst_notif", 32'(PLIC_notif), 32'd0);
        check("rst_ready", 32'(bif.bus_ready), 32'd0);
        bif.bus_valid = 1'b1;
        bif.bus_we    = 1'b0;
        bif.bus_addr  = 8'h84;
        tick(1);
        check("rst_drop_ready", 32'(bif.bus_ready), 32'd0);
        bif.bus_valid = 1'b0;
        resetn = 1'b1;
        rd(8'h80, 32'd0);
        rd(8'h84, 32'd0);
        rd(8'h88, 32'd0);
        rd(8'h0C, 32'd0);

        // basic path
        wr(8'h0C, 32'd2);
        wr(8'h84, 32'h08);
        wr(8'h88, 32'd0);
        irq_src[2] = 1'b1;
        check("basic_notif_before_edge", 32'(PLIC_notif), 32'd0);
        tick(1);
        check("basic_notif", 32'(PLIC_notif), 32'd1);
        rd(8'h80, 32'h08);
        rd(8'h8C, 32'd3);
        check("basic_notif_after_claim", 32'(PLIC_notif), 32'd0);
        irq_src[2] = 1'b0;
        wr(8'h8C, 32'd3);
        tick(2);
        check("basic_no_repend", 32'(PLIC_notif), 32'd0);
        rd(8'h80, 32'd0);

        // priority and tie-break with back-to-back claims
        apply_reset();
        wr(8'h08, 32'd4);
        wr(8'h14, 32'd4);
        wr(8'h18, 32'd1);
        wr(8'h84, 32'hFFFF_FFFF);
        rd(8'h84, 32'h1FE);
        irq_src = 8'hFF;
        tick(1);
        check("prio_notif", 32'(PLIC_notif), 32'd1);
        rd(8'h8C, 32'd2);
        rd(8'h8C, 32'd5);
        rd(8'h8C, 32'd6);
        rd(8'h8C, 32'd0);
        check("prio_notif_drained", 32'(PLIC_notif), 32'd0);
        rd(8'h80, 32'h19A);

        // threshold
        apply_reset();
        wr(8'h04, 32'd3);
        wr(8'h84, 32'h02);
        wr(8'h88, 32'd3);
        irq_src[0] = 1'b1;
        tick(2);
        check("thr_blocked", 32'(PLIC_notif), 32'd0);
        rd(8'h80, 32'h02);
        wr(8'h88, 32'd2);
        check("thr_open", 32'(PLIC_notif), 32'd1);

        // level re-trigger
        apply_reset();
        wr(8'h10, 32'd5);
        wr(8'h84, 32'h10);
        irq_src[3] = 1'b1;
        tick(2);
        check("lvl_notif", 32'(PLIC_notif), 32'd1);
        rd(8'h8C, 32'd4);
        check("lvl_claimed", 32'(PLIC_notif), 32'd0);
        tick(3);
        check("lvl_held", 32'(PLIC_notif), 32'd0);
        rd(8'h80, 32'd0);
        wr(8'h8C, 32'd4);
        check("lvl_cmpl_same_cycle", 32'(PLIC_notif), 32'd0);
        tick(1);
        check("lvl_repend", 32'(PLIC_notif), 32'd1);
        rd(8'h80, 32'h10);

        // claim with line still high, then ignored completes
        rd(8'h8C, 32'd4);
        rd(8'h80, 32'd0);
        wr(8'h8C, 32'd0);
        wr(8'h8C, 32'd9);
        wr(8'h8C, 32'd3);
        tick(1);
        check("edge_ignored_cmpl", 32'(PLIC_notif), 32'd0);
        rd(8'h80, 32'd0);
        wr(8'h8C, 32'h24);
        tick(1);
        check("edge_real_cmpl", 32'(PLIC_notif), 32'd1);

        // register field widths, unmapped and read-only locations
        wr(8'h20, 32'hFF);
        rd(8'h20, 32'd7);
        rd(8'h24, 32'd0);
        rd(8'h00, 32'd0);
        rd(8'hA0, 32'd0);
        wr(8'h80, 32'd0);
        rd(8'h80, 32'h10);
        wr(8'h88, 32'hFFFF_FFFF);
        rd(8'h88, 32'd7);
        check("thr_max_notif", 32'(PLIC_notif), 32'd0);

        tick(3);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
